// File: rtl/pulses_pkg.sv
// Shared definitions for the pulse-echo acquisition blocks: default widths
// and the integrator FSM state encoding.
package pulses_pkg;

  localparam int ADC_W_DEF  = 12;
  localparam int ACC_W_DEF  = 40;
  localparam int NAVG_W_DEF = 16;
  localparam int RES_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SHOT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer with synchronous active-low clear.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous level through two flops into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/echo_integrator.sv
// Echo integrator: sums ADC samples that fall inside the open echo window
// (sync high, inhibit low) over n_avg trigger pulses, with saturation.
module echo_integrator
  import pulses_pkg::*;
#(
  parameter int ADC_W  = ADC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int NAVG_W = NAVG_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sync_in,
  input  logic                    inhib_in,
  input  logic [ADC_W-1:0]        adc_data,
  input  logic                    adc_valid,
  input  logic [NAVG_W-1:0]       n_avg,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic signed [ACC_W-1:0] res_data,
  output logic [RES_CNT_W-1:0]    res_count,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    overflow
);

  localparam logic [ACC_W-1:0]     ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]     ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]     ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [NAVG_W-1:0]    NAVG_ZERO = {NAVG_W{1'b0}};
  localparam logic [NAVG_W-1:0]    NAVG_ONE  = {{(NAVG_W-1){1'b0}}, 1'b1};
  localparam logic [RES_CNT_W-1:0] CNT_MAX   = {RES_CNT_W{1'b1}};
  localparam logic [RES_CNT_W-1:0] CNT_ZERO  = {RES_CNT_W{1'b0}};
  localparam logic [RES_CNT_W-1:0] CNT_ONE   = {{(RES_CNT_W-1){1'b0}}, 1'b1};

  // Synchronized control levels and the aligned sample pipeline
  logic             sync_s;
  logic             inhib_s;
  logic             sync_prev_q;
  logic [ADC_W-1:0] adc_d1_q;
  logic [ADC_W-1:0] adc_d2_q;
  logic             vld_d1_q;
  logic             vld_d2_q;

  // Control state
  state_e            state_q;
  state_e            state_d;
  logic [NAVG_W-1:0] navg_q;
  logic [NAVG_W-1:0] shot_q;
  logic [NAVG_W-1:0] shot_inc_s;
  logic              busy_q;
  logic              res_valid_q;

  // Datapath
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;
  logic [RES_CNT_W-1:0] cnt_q;
  logic [RES_CNT_W-1:0] cnt_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [ADC_W-1:0]     samp_flip_s;
  logic [ACC_W-1:0]     sample_s;
  logic [ACC_W:0]       sum_s;

  // Decoded events and FSM controls
  logic sync_rise_s;
  logic sync_fall_s;
  logic last_shot_s;
  logic start_acq_s;
  logic acc_en_s;
  logic shot_done_s;

  sync_2ff u_sync_trig (
    .clk   (clk),
    .reset (reset),
    .d_i   (sync_in),
    .q_o   (sync_s)
  );

  sync_2ff u_sync_inhib (
    .clk   (clk),
    .reset (reset),
    .d_i   (inhib_in),
    .q_o   (inhib_s)
  );

  assign sync_rise_s = sync_s & ~sync_prev_q;
  assign sync_fall_s = ~sync_s & sync_prev_q;
  assign shot_inc_s  = shot_q + NAVG_ONE;
  assign last_shot_s = (shot_inc_s == navg_q);

  // Offset-binary to two's complement: flip the MSB, then sign-extend.
  assign samp_flip_s = {~adc_d2_q[ADC_W-1], adc_d2_q[ADC_W-2:0]};
  assign sample_s    = {{(ACC_W-ADC_W){samp_flip_s[ADC_W-1]}}, samp_flip_s};
  assign sum_s       = {acc_q[ACC_W-1], acc_q} + {sample_s[ACC_W-1], sample_s};

  // Delay the ADC stream by two cycles so it lines up with the synchronized levels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      adc_d1_q    <= {ADC_W{1'b0}};
      adc_d2_q    <= {ADC_W{1'b0}};
      vld_d1_q    <= 1'b0;
      vld_d2_q    <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      adc_d1_q    <= adc_data;
      adc_d2_q    <= adc_d1_q;
      vld_d1_q    <= adc_valid;
      vld_d2_q    <= vld_d1_q;
      sync_prev_q <= sync_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort only matters while an acquisition is running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
        else       state_d = ST_IDLE;
      end
      ST_ARM: begin
        if (abort)            state_d = ST_IDLE;
        else if (sync_rise_s) state_d = ST_SHOT;
        else                  state_d = ST_ARM;
      end
      ST_SHOT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sync_fall_s) begin
          if (last_shot_s) state_d = ST_DONE;
          else             state_d = ST_ARM;
        end else begin
          state_d = ST_SHOT;
        end
      end
      ST_DONE: begin
        if (res_valid_q && res_ready) state_d = ST_IDLE;
        else                          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath clear, accumulate enable and shot completion.
  always_comb begin
    start_acq_s = 1'b0;
    acc_en_s    = 1'b0;
    shot_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_acq_s = start;
      end
      ST_SHOT: begin
        acc_en_s    = sync_s & ~inhib_s & vld_d2_q & ~abort;
        shot_done_s = sync_fall_s & ~abort;
      end
      ST_ARM: begin
        start_acq_s = 1'b0;
      end
      ST_DONE: begin
        start_acq_s = 1'b0;
      end
      default: begin
        start_acq_s = 1'b0;
      end
    endcase
  end

  // Saturating accumulate of the aligned sample plus saturating sample count.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (start_acq_s) begin
      acc_d = ACC_ZERO;
      cnt_d = CNT_ZERO;
      ovf_d = 1'b0;
    end else if (acc_en_s) begin
      if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
        ovf_d = 1'b1;
        if (sum_s[ACC_W]) acc_d = ACC_MIN;
        else              acc_d = ACC_MAX;
      end else begin
        acc_d = sum_s[ACC_W-1:0];
      end
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      else                  cnt_d = cnt_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Result registers and shot bookkeeping; a zero shot request runs one shot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q       <= ACC_ZERO;
      cnt_q       <= CNT_ZERO;
      ovf_q       <= 1'b0;
      navg_q      <= NAVG_ONE;
      shot_q      <= NAVG_ZERO;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= (state_d != ST_IDLE);
      res_valid_q <= (state_d == ST_DONE);
      if (start_acq_s) begin
        navg_q <= (n_avg == NAVG_ZERO) ? NAVG_ONE : n_avg;
        shot_q <= NAVG_ZERO;
      end else if (shot_done_s) begin
        shot_q <= shot_inc_s;
      end
    end
  end

  assign busy      = busy_q;
  assign res_data  = acc_q;
  assign res_count = cnt_q;
  assign res_valid = res_valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_echo_integrator.sv
// Scoreboard bench for echo_integrator: a default-width instance and a
// 16-bit accumulator instance share stimulus; expected results are queued
// at start and compared when each instance presents its result.
module tb_echo_integrator;

  typedef struct {
    longint data;
    longint cnt;
    bit     ovf;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               sync_in;
  logic               inhib_in;
  logic [11:0]        adc_data;
  logic               adc_valid;
  logic [15:0]        n_avg;
  logic               start;
  logic               abort;
  logic               res_ready;

  logic               busy,      busy16;
  logic signed [39:0] res_data;
  logic signed [15:0] res_data16;
  logic [31:0]        res_count, res_count16;
  logic               res_valid, res_valid16;
  logic               overflow,  overflow16;

  exp_t q40[$];
  exp_t q16[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  echo_integrator dut (
    .clk(clk), .reset(reset), .sync_in(sync_in), .inhib_in(inhib_in),
    .adc_data(adc_data), .adc_valid(adc_valid), .n_avg(n_avg),
    .start(start), .abort(abort), .busy(busy), .res_data(res_data),
    .res_count(res_count), .res_valid(res_valid), .res_ready(res_ready),
    .overflow(overflow)
  );

  echo_integrator #(.ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .sync_in(sync_in), .inhib_in(inhib_in),
    .adc_data(adc_data), .adc_valid(adc_valid), .n_avg(n_avg),
    .start(start), .abort(abort), .busy(busy16), .res_data(res_data16),
    .res_count(res_count16), .res_valid(res_valid16), .res_ready(res_ready),
    .overflow(overflow16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic sat_step(inout longint acc, inout bit ov, input longint v, input int w);
    longint mx;
    longint mn;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -mx - 1;
    acc = acc + v;
    if (acc > mx) begin
      acc = mx;
      ov  = 1'b1;
    end else if (acc < mn) begin
      acc = mn;
      ov  = 1'b1;
    end
  endtask

  // Reference model: offset-binary value minus mid-scale, summed with clamping.
  task automatic push_exp(input int shots, input int pre, input int win, input int skip,
                          input logic [11:0] val);
    exp_t   e40, e16;
    longint v;
    v = longint'(val) - 2048;
    e40 = '{0, 0, 1'b0};
    e16 = '{0, 0, 1'b0};
    for (int s = 0; s < shots; s++) begin
      for (int c = pre; c < pre + win; c++) begin
        if (skip == 0 || (c % skip) != 0) begin
          sat_step(e40.data, e40.ovf, v, 40);
          sat_step(e16.data, e16.ovf, v, 16);
          e40.cnt++;
          e16.cnt++;
        end
      end
    end
    q40.push_back(e40);
    q16.push_back(e16);
  endtask

  // One sync pulse of hi cycles with the window open for cycles [pre, pre+win).
  task automatic run_shot(input int hi, input int pre, input int win, input int skip,
                          input logic [11:0] val);
    for (int c = 0; c < hi; c++) begin
      sync_in   = 1'b1;
      inhib_in  = !(c >= pre && c < pre + win);
      adc_data  = val;
      adc_valid = !(skip != 0 && (c % skip) == 0);
      @(negedge clk);
    end
    sync_in  = 1'b0;
    inhib_in = 1'b1;
  endtask

  task automatic wait_result(input int hold, input bit chk_lat);
    int   k;
    exp_t e40, e16;
    k = 0;
    while (!res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid || q40.size() == 0) begin
      check_val("result_timeout", {63'd0, res_valid}, 64'd2);
      q40.delete();
      q16.delete();
      return;
    end
    if (chk_lat) check_val("rv_latency", k, 3);
    e40 = q40.pop_front();
    e16 = q16.pop_front();
    for (int d = 0; d < hold; d++) begin
      check_val("hold_valid", res_valid, 1);
      check_val("hold_data", res_data, e40.data);
      check_val("hold_data16", res_data16, e16.data);
      if (d == 1) begin
        start = 1'b1;
        abort = 1'b1;
        n_avg = 16'd5;
      end else begin
        start = 1'b0;
        abort = 1'b0;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b1;
    check_val("res_valid", res_valid, 1);
    check_val("res_valid16", res_valid16, 1);
    check_val("res_data", res_data, e40.data);
    check_val("res_count", res_count, e40.cnt);
    check_val("overflow", overflow, e40.ovf);
    check_val("res_data16", res_data16, e16.data);
    check_val("res_count16", res_count16, e16.cnt);
    check_val("overflow16", overflow16, e16.ovf);
    @(negedge clk);
    res_ready = 1'b0;
    check_val("rv_drop", res_valid, 0);
    check_val("busy_drop", busy, 0);
    check_val("busy_drop16", busy16, 0);
  endtask

  task automatic do_acq(input logic [15:0] nav, input int hi, input int pre, input int win,
                        input int skip, input logic [11:0] val, input int hold,
                        input bit with_abort);
    int eff;
    eff   = (nav == 16'd0) ? 1 : int'(nav);
    n_avg = nav;
    start = 1'b1;
    abort = with_abort;
    push_exp(eff, pre, win, skip, val);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_val("busy_after_start", busy, 1);
    repeat (2) @(negedge clk);
    for (int s = 0; s < eff; s++) begin
      run_shot(hi, pre, win, skip, val);
      if (s != eff - 1) repeat (4) @(negedge clk);
    end
    wait_result(hold, 1'b1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (res_valid || res_valid16 || busy) seen++;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    reset     = 1'b0;
    sync_in   = 1'b0;
    inhib_in  = 1'b1;
    adc_data  = 12'h000;
    adc_valid = 1'b0;
    n_avg     = 16'd0;
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", res_valid, 0);
    check_val("rst_data", res_data, 0);
    check_val("rst_count", res_count, 0);
    check_val("rst_ovf", overflow, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single shot, long sync, 20-sample window, result held 10 cycles.
    do_acq(16'd1, 100, 30, 20, 0, 12'h900, 10, 1'b0);

    // Four negative-valued shots; a fifth pulse must not be consumed.
    do_acq(16'd4, 30, 5, 10, 0, 12'h700, 2, 1'b0);
    run_shot(30, 5, 10, 0, 12'h700);
    expect_quiet("extra_pulse", 20);

    // Sync already high at start: that pulse is ignored.
    sync_in = 1'b1; inhib_in = 1'b0; adc_data = 12'h900; adc_valid = 1'b1;
    repeat (5) @(negedge clk);
    n_avg = 16'd1;
    start = 1'b1;
    push_exp(1, 5, 7, 0, 12'hA00);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    sync_in = 1'b0; inhib_in = 1'b1;
    repeat (4) @(negedge clk);
    run_shot(40, 5, 7, 0, 12'hA00);
    wait_result(0, 1'b1);

    // Positive full-scale over 100 shots: saturates only the 16-bit instance.
    do_acq(16'd100, 60, 5, 50, 0, 12'hFFF, 1, 1'b0);

    // n_avg of zero runs one shot; adc_valid gaps are not accumulated.
    do_acq(16'd0, 30, 4, 12, 3, 12'h123, 0, 1'b0);

    // Abort in the middle of the second shot of three.
    n_avg = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    run_shot(30, 5, 10, 0, 12'h900);
    repeat (4) @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      sync_in = 1'b1; inhib_in = 1'b0;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_busy16", busy16, 0);
    sync_in = 1'b0; inhib_in = 1'b1;
    expect_quiet("abort_no_rv", 30);
    // Start wins over a simultaneous abort in IDLE.
    do_acq(16'd2, 20, 4, 6, 0, 12'h880, 0, 1'b1);

    // Reset in the middle of a shot clears everything; no result follows.
    n_avg = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      sync_in = 1'b1; inhib_in = !(c >= 3); adc_data = 12'hC00; adc_valid = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_valid", res_valid, 0);
    check_val("mid_rst_data", res_data, 0);
    check_val("mid_rst_count", res_count, 0);
    check_val("mid_rst_ovf", overflow, 0);
    check_val("mid_rst_data16", res_data16, 0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    sync_in = 1'b0; inhib_in = 1'b1;
    repeat (4) @(negedge clk);
    run_shot(20, 3, 6, 0, 12'hC00);
    expect_quiet("post_rst_quiet", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
